// File: rtl/uart_boot_loader_if.sv
// rtl/uart_boot_loader_if.sv - RAM write port driven by the boot loader
interface uart_boot_loader_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_we;

    modport master (output mem_addr, output mem_data, output mem_we);
    modport slave  (input  mem_addr, input  mem_data, input  mem_we);
endinterface

// File: rtl/uart_boot_loader.sv
// rtl/uart_boot_loader.sv - 8N1 UART receiver and frame parser that loads a program image into RAM
// Frame: A5, N lo, N hi, then N little-endian words written from BASE_ADDR upward.
module uart_boot_loader #(
    parameter int          CLKS_PER_BIT = 434,
    parameter logic [31:0] BASE_ADDR    = 32'h0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rx,
    uart_boot_loader_if.master         mem,
    output logic                       core_run,
    output logic                       busy,
    output logic                       frame_err
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [2:0] P_SYNC   = 3'd0;
    localparam logic [2:0] P_LEN_LO = 3'd1;
    localparam logic [2:0] P_LEN_HI = 3'd2;
    localparam logic [2:0] P_DATA   = 3'd3;
    localparam logic [2:0] P_DONE   = 3'd4;

    logic          rx_meta, rx_sync;
    logic [1:0]    rx_state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          byte_valid;

    logic [2:0]    p_state;
    logic [15:0]   n_words;
    logic [15:0]   idx;
    logic [15:0]   idx_next;
    logic [1:0]    bcnt;
    logic [23:0]   word;

    assign idx_next = idx + 16'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_state   <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= 3'd0;
            shreg      <= 8'd0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_sync    <= rx_meta;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    cnt <= '0;
                    if (!rx_sync) rx_state <= RX_START;
                end
                RX_START: begin
                    if (cnt == HALF_M1) begin
                        cnt      <= '0;
                        bit_idx  <= 3'd0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt   <= '0;
                        shreg <= {rx_sync, shreg[7:1]};
                        if (bit_idx == 3'd7) rx_state <= RX_STOP;
                        else bit_idx <= bit_idx + 3'd1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    // Returning to idle at the stop mid-sample lets a back-to-back start bit be caught.
                    if (cnt == FULL_M1) begin
                        cnt      <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_sync) byte_valid <= 1'b1;
                        else frame_err <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_state      <= P_SYNC;
            n_words      <= 16'd0;
            idx          <= 16'd0;
            bcnt         <= 2'd0;
            word         <= 24'd0;
            mem.mem_addr <= BASE_ADDR;
            mem.mem_data <= 32'd0;
            mem.mem_we   <= 1'b0;
            core_run     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            mem.mem_we <= 1'b0;
            if (frame_err) begin
                p_state  <= P_SYNC;
                core_run <= 1'b0;
                busy     <= 1'b0;
            end else begin
                case (p_state)
                    P_SYNC: if (byte_valid && shreg == 8'hA5) begin
                        core_run <= 1'b0;
                        busy     <= 1'b1;
                        p_state  <= P_LEN_LO;
                    end
                    P_LEN_LO: if (byte_valid) begin
                        n_words[7:0] <= shreg;
                        p_state      <= P_LEN_HI;
                    end
                    P_LEN_HI: if (byte_valid) begin
                        n_words[15:8] <= shreg;
                        idx           <= 16'd0;
                        bcnt          <= 2'd0;
                        if ({shreg, n_words[7:0]} == 16'd0) begin
                            core_run <= 1'b1;
                            busy     <= 1'b0;
                            p_state  <= P_SYNC;
                        end else begin
                            p_state <= P_DATA;
                        end
                    end
                    P_DATA: if (byte_valid) begin
                        word <= {shreg, word[23:8]};
                        bcnt <= bcnt + 2'd1;
                        if (bcnt == 2'd3) begin
                            mem.mem_data <= {shreg, word};
                            mem.mem_addr <= BASE_ADDR + {16'h0, idx};
                            mem.mem_we   <= 1'b1;
                            idx          <= idx_next;
                            if (idx_next == n_words) p_state <= P_DONE;
                        end
                    end
                    P_DONE: begin
                        // Sits one cycle behind the final write so core_run follows mem_we.
                        core_run <= 1'b1;
                        busy     <= 1'b0;
                        p_state  <= P_SYNC;
                    end
                    default: p_state <= P_SYNC;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_boot_loader.sv
// tb/tb_uart_boot_loader.sv - self-checking bench for uart_boot_loader
module tb_uart_boot_loader;
    localparam int          CPB  = 8;
    localparam logic [31:0] BASE = 32'h10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx = 1'b1;
    logic core_run, busy, frame_err;

    uart_boot_loader_if mem_bus();

    uart_boot_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .mem(mem_bus),
        .core_run(core_run), .busy(busy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    logic [7:0]  tx_q[$];
    int cyc = 0, writes = 0, last_we_cyc = -100, rise_gap = -1, ferr_cnt = 0;
    logic prev_run = 1'b0;
    logic [63:0] mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (frame_err) ferr_cnt++;
            if (mem_bus.mem_we) begin
                writes++;
                last_we_cyc = cyc;
                chk("we_while_core_run", {31'd0, core_run}, 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %h data %h, no write required",
                             mem_bus.mem_addr, mem_bus.mem_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("write_addr", mem_bus.mem_addr, mon_e[63:32]);
                    chk("write_data", mem_bus.mem_data, mon_e[31:0]);
                end
            end
            if (core_run && !prev_run) rise_gap = cyc - last_we_cyc;
        end
        prev_run = core_run;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic send_q();
        while (tx_q.size() > 0) send_byte(tx_q.pop_front(), 1'b1);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reset_values();
        chk("rst_mem_addr", mem_bus.mem_addr, BASE);
        chk("rst_mem_data", mem_bus.mem_data, 32'd0);
        chk("rst_mem_we", {31'd0, mem_bus.mem_we}, 32'd0);
        chk("rst_core_run", {31'd0, core_run}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    endtask

    // Reference: a frame of n random words must produce writes BASE+i in order.
    task automatic queue_frame(input int n);
        logic [31:0] w;
        logic [15:0] nn;
        nn = 16'(n);
        tx_q.push_back(8'hA5);
        tx_q.push_back(nn[7:0]);
        tx_q.push_back(nn[15:8]);
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            exp_q.push_back({BASE + 32'(i), w});
            for (int k = 0; k < 4; k++) tx_q.push_back(8'((w >> (8 * k)) & 32'hFF));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int w0, f0, junk;
        logic r0, b0;
        logic [7:0] jb;

        repeat (3) @(negedge clk);
        chk_reset_values();
        rst_n = 1'b1;
        idle(4);

        exp_q.push_back({32'h10, 32'h12345678});
        exp_q.push_back({32'h11, 32'hDEADBEEF});
        send_byte(8'hA5, 1'b1);
        chk("t1_busy_after_sync", {31'd0, busy}, 32'd1);
        chk("t1_run_after_sync", {31'd0, core_run}, 32'd0);
        tx_q = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_q();
        idle(4);
        chk("t1_core_run", {31'd0, core_run}, 32'd1);
        chk("t1_busy", {31'd0, busy}, 32'd0);
        chk("t1_run_gap", 32'(rise_gap), 32'd1);
        chk("t1_writes", 32'(writes), 32'd2);
        chk("t1_pending", 32'(exp_q.size()), 32'd0);

        w0 = writes;
        tx_q = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00};
        send_q();
        idle(4);
        chk("t2_writes", 32'(writes), 32'(w0));
        chk("t2_core_run", {31'd0, core_run}, 32'd1);
        chk("t2_busy", {31'd0, busy}, 32'd0);

        w0 = writes;
        f0 = ferr_cnt;
        tx_q = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
        send_q();
        send_byte(8'h33, 1'b0);
        idle(2 * CPB);
        chk("t3_frame_err_pulses", 32'(ferr_cnt - f0), 32'd1);
        chk("t3_writes", 32'(writes), 32'(w0));
        chk("t3_core_run", {31'd0, core_run}, 32'd0);
        chk("t3_busy", {31'd0, busy}, 32'd0);
        exp_q.push_back({32'h10, 32'hDDCCBBAA});
        tx_q = '{8'hA5, 8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_q();
        idle(4);
        chk("t3_reload_run", {31'd0, core_run}, 32'd1);
        chk("t3_pending", 32'(exp_q.size()), 32'd0);

        w0 = writes; f0 = ferr_cnt; r0 = core_run; b0 = busy;
        rx = 1'b0;
        repeat (2) @(negedge clk);
        idle(5 * CPB);
        chk("t4_glitch_ferr", 32'(ferr_cnt), 32'(f0));
        chk("t4_glitch_writes", 32'(writes), 32'(w0));
        chk("t4_glitch_run", {31'd0, core_run}, {31'd0, r0});
        chk("t4_glitch_busy", {31'd0, busy}, {31'd0, b0});

        exp_q.push_back({BASE, 32'h04030201});
        send_byte(8'hA5, 1'b1);
        chk("t5_run_dropped", {31'd0, core_run}, 32'd0);
        chk("t5_busy_set", {31'd0, busy}, 32'd1);
        tx_q = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
        send_q();
        idle(4);
        chk("t5_run_again", {31'd0, core_run}, 32'd1);
        chk("t5_pending", 32'(exp_q.size()), 32'd0);

        for (int f = 0; f < 6; f++) begin
            junk = $urandom_range(0, 2);
            for (int j = 0; j < junk; j++) begin
                jb = 8'($urandom_range(0, 255));
                if (jb == 8'hA5) jb = 8'h3C;
                tx_q.push_back(jb);
            end
            queue_frame($urandom_range(0, 3));
            send_q();
            idle(3);
            chk("rand_core_run", {31'd0, core_run}, 32'd1);
            chk("rand_busy", {31'd0, busy}, 32'd0);
            chk("rand_pending", 32'(exp_q.size()), 32'd0);
        end

        w0 = writes;
        tx_q = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'hFF, 8'h44};
        fork
            send_q();
            begin
                repeat (5 * 10 * CPB + 5 * CPB) @(negedge clk);
                rst_n = 1'b0;
                #1;
                chk_reset_values();
                @(negedge clk);
                rst_n = 1'b1;
            end
        join
        idle(4 * CPB);
        chk("t6_writes", 32'(writes), 32'(w0));
        chk("t6_core_run", {31'd0, core_run}, 32'd0);
        chk("t6_busy", {31'd0, busy}, 32'd0);

        chk("final_pending", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_boot_loader.md
# uart_boot_loader

Serial boot loader that sits upstream of the processor core and its single-port program/data RAM. It receives a framed program image over an 8N1 UART line and writes it word-by-word into RAM through the same port the core later uses. It holds the core stalled until the image is complete, then releases it. This is the only path by which code enters the core after reset.

## Interface
- `CLKS_PER_BIT`, 434: clock cycles per UART bit (50 MHz / 115200). Must be ≥ 4.
- `BASE_ADDR`, 32'h0: RAM word address of the first loaded word.
- `clk` input, 1: system clock, shared with core and RAM.
- `rst_n` input, 1: one clock; reset is asynchronous and active-low.
- `rx` input, 1: UART receive line, idle high, asynchronous to `clk`.
- `mem_addr` output, 32: RAM word address, muxed onto the RAM port while `core_run`=0.
- `mem_data` output, 32: RAM write data.
- `mem_we` output, 1: RAM write enable, single-cycle pulse per word.
- `core_run` output, 1: 1 = core owns RAM and advances; 0 = core held in FETCH with PC forced to `BASE_ADDR`.
- `busy` output, 1: high from accepted sync byte until `core_run` rises.
- `frame_err` output, 1: one-cycle pulse on a bad stop bit.

## Operation
- Receiver:
  - `rx` passes through a 2-flop synchronizer.
  - A falling edge starts a bit counter. The start bit is re-sampled at `CLKS_PER_BIT/2`; if it reads 1, it is a glitch and the receiver returns to idle.
  - Data bits are sampled at mid-bit, LSB first. The stop bit is sampled at mid-bit.
  - Stop = 1: internal `byte_valid` pulses for 1 cycle with the byte.
  - Stop = 0: byte discarded, `frame_err` pulses, parser forced to SYNC.
- Frame format: 0xA5, then N low byte, then N high byte (N = 16-bit word count), then N×4 data bytes. Each word is little-endian (first byte → bits [7:0]).
- Parser states:
  - SYNC: wait for 0xA5; all other bytes are ignored. On 0xA5: `core_run`←0, `busy`←1, go to LEN_LO.
  - LEN_LO: latch N[7:0], go to LEN_HI.
  - LEN_HI: latch N[15:8], clear word index and byte count. If N = 0, go to DONE; otherwise go to DATA.
  - DATA: shift each byte into the word assembler. On the 4th byte, write the word:
    - `mem_data` = word, `mem_addr` = `BASE_ADDR` + index, `mem_we` = 1.
    - Index increments.
    - When index reaches N, go to DONE.
  - DONE: `busy`←0, `core_run`←1. `core_run` holds until reset or a new 0xA5, which re-enters LEN_LO with `core_run`←0 (reload).
- Address arithmetic is 32-bit modulo 2^32. The index is 16-bit; N = 65535 is the maximum.
- A frame error in any state returns the parser to SYNC and leaves `core_run`=0, `busy`=0. Words already written stay in RAM.
- `mem_we` is never asserted while `core_run`=1.

## Timing
- Reset values: `mem_addr`=`BASE_ADDR`, `mem_data`=0, `mem_we`=0, `core_run`=0, `busy`=0, `frame_err`=0. Parser is in SYNC, receiver idle.
- Reset mid-frame aborts immediately. The partial word is dropped; no write occurs.
- `byte_valid` occurs 2 (sync) + 9.5×`CLKS_PER_BIT` cycles after the start-bit falling edge reaches `rx`.
- `mem_we`, `mem_addr` and `mem_data` are registered and asserted on the cycle after `byte_valid` of the 4th byte. They are valid together for exactly 1 cycle.
- `core_run` rises on the cycle after the last `mem_we` pulse. For N = 0, it rises on the cycle after LEN_HI's `byte_valid`.
- `core_run` falls on the cycle after `byte_valid` of a reload 0xA5.
- `frame_err` is asserted the cycle after the stop-bit sample.
- Back-to-back bytes with no idle gap are accepted. The receiver re-arms at the stop-bit mid-sample.

## Test plan
- `CLKS_PER_BIT`=8, `BASE_ADDR`=0x10. Send A5 02 00 78 56 34 12 EF BE AD DE. Expect writes [0x10]=0x12345678, then [0x11]=0xDEADBEEF, one `mem_we` pulse each. `core_run` rises 1 cycle after the 2nd write; `busy` falls at the same time.
- Send 00 FF A5 00 00. Expect no `mem_we`; `core_run` rises after the last byte; leading junk is ignored.
- Send A5 01 00 11 22, then a byte with stop bit = 0. Expect a `frame_err` pulse, no write, parser in SYNC. Then A5 01 00 AA BB CC DD → [BASE]=0xDDCCBBAA.
- Drive a 2-cycle low glitch on idle `rx`. Expect no `byte_valid`, no state change.
- After a completed load (`core_run`=1), send A5 01 00 01 02 03 04. Expect `core_run`=0 from the 0xA5, a write of 0x04030201 to BASE, then `core_run`=1 again.
- Assert `rst_n` low midway through the 3rd data byte. Expect all outputs at reset values immediately; no write afterwards, even though the remaining bytes complete on the line.
